// File: rtl/alu_op_sequencer.sv
// Multicycle control sequencer for the Y -> ALU -> Z -> regfile/HI/LO transfer path.
// Moore FSM: every strobe is decoded from the current state and the latched opcode.
module alu_op_sequencer #(
    parameter int MUL_WAIT = 2,
    parameter int DIV_WAIT = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       start,
    input  logic [4:0] opcode,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] alu_instruction,
    output logic       gra,
    output logic       grb,
    output logic       grc,
    output logic       r_out,
    output logic       r_in,
    output logic       c_out,
    output logic       y_in,
    output logic       z_in,
    output logic       zlo_out,
    output logic       zhi_out,
    output logic       lo_in,
    output logic       hi_in
);

    localparam logic [3:0] MUL_W = 4'(MUL_WAIT);
    localparam logic [3:0] DIV_W = 4'(DIV_WAIT);
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_Y, S_EXEC, S_WAIT, S_WB_LO, S_WB_HI, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic       error_q, error_d;

    logic       in_legal, in_u;
    logic       is_i, is_md, is_u;
    logic [3:0] wait_val;

    assign in_legal = (opcode >= 5'd3) && (opcode <= 5'd18);
    assign in_u     = (opcode == 5'd17) || (opcode == 5'd18);
    assign is_i     = (op_q >= 5'd12) && (op_q <= 5'd14);
    assign is_md    = (op_q == OP_MUL) || (op_q == OP_DIV);
    assign is_u     = (op_q == 5'd17) || (op_q == 5'd18);
    assign wait_val = (op_q == OP_DIV) ? DIV_W : MUL_W;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        cnt_d           = cnt_q;
        error_d         = error_q;
        done            = 1'b0;
        alu_instruction = '0;
        gra             = 1'b0;
        grb             = 1'b0;
        grc             = 1'b0;
        r_out           = 1'b0;
        r_in            = 1'b0;
        c_out           = 1'b0;
        y_in            = 1'b0;
        z_in            = 1'b0;
        zlo_out         = 1'b0;
        zhi_out         = 1'b0;
        lo_in           = 1'b0;
        hi_in           = 1'b0;

        // EXEC and WAIT share the same operand source onto the bus
        if (state_q == S_EXEC || state_q == S_WAIT) begin
            alu_instruction = op_q;
            if (is_i) begin
                c_out = 1'b1;
            end else if (is_u) begin
                grb   = 1'b1;
                r_out = 1'b1;
            end else begin
                grc   = 1'b1;
                r_out = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (in_legal) begin
                        op_d    = opcode;
                        error_d = 1'b0;
                        state_d = in_u ? S_EXEC : S_LOAD_Y;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD_Y: begin
                grb     = 1'b1;
                r_out   = 1'b1;
                y_in    = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_md && wait_val != 4'd0) begin
                    cnt_d   = wait_val - 4'd1;
                    state_d = S_WAIT;
                end else begin
                    z_in    = 1'b1;
                    state_d = S_WB_LO;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    z_in    = 1'b1;
                    state_d = S_WB_LO;
                end
            end
            S_WB_LO: begin
                zlo_out = 1'b1;
                if (is_md) begin
                    lo_in   = 1'b1;
                    state_d = S_WB_HI;
                end else begin
                    gra     = 1'b1;
                    r_in    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WB_HI: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign error = error_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: per-cycle strobe comparison against a phase-list model,
// a latency/error vector table, random opcodes with start noise, and corner sequences.
module tb_alu_op_sequencer;

    localparam int MUL_WAIT = 2;
    localparam int DIV_WAIT = 4;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       start = 1'b0;
    logic [4:0] opcode = '0;
    logic       busy, done, error;
    logic [4:0] alu_instruction;
    logic       gra, grb, grc, r_out, r_in, c_out, y_in, z_in;
    logic       zlo_out, zhi_out, lo_in, hi_in;

    always #5 clock = ~clock;

    alu_op_sequencer #(.MUL_WAIT(MUL_WAIT), .DIV_WAIT(DIV_WAIT)) dut (
        .clock(clock), .clear(clear), .start(start), .opcode(opcode),
        .busy(busy), .done(done), .error(error), .alu_instruction(alu_instruction),
        .gra(gra), .grb(grb), .grc(grc), .r_out(r_out), .r_in(r_in), .c_out(c_out),
        .y_in(y_in), .z_in(z_in), .zlo_out(zlo_out), .zhi_out(zhi_out),
        .lo_in(lo_in), .hi_in(hi_in)
    );

    typedef struct packed {
        logic       busy, done, error;
        logic [4:0] alu;
        logic       gra, grb, grc, r_out, r_in, c_out, y_in, z_in;
        logic       zlo_out, zhi_out, lo_in, hi_in;
    } obs_t;

    obs_t obs;
    assign obs = {busy, done, error, alu_instruction, gra, grb, grc, r_out, r_in,
                  c_out, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in};

    typedef struct {
        logic [4:0] op;
        int         lat;
        logic       err;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    logic exp_err = 1'b0;

    task automatic cmp(input string nm, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, want);
        end
    endtask

    // Expected per-cycle outputs from acceptance to DONE, built from the op's phase list.
    task automatic build_exp(input logic [4:0] op);
        obs_t e;
        int   n_exec;
        bit   md, it, ut;
        exp_q.delete();
        if (op < 5'd3 || op > 5'd18) begin
            e = '0; e.busy = 1; e.done = 1; e.error = 1;
            exp_q.push_back(e);
            exp_err = 1'b1;
        end else begin
            exp_err = 1'b0;
            md = (op == 5'd15) || (op == 5'd16);
            it = (op >= 5'd12) && (op <= 5'd14);
            ut = (op >= 5'd17);
            if (!ut) begin
                e = '0; e.busy = 1; e.grb = 1; e.r_out = 1; e.y_in = 1;
                exp_q.push_back(e);
            end
            n_exec = 1 + ((op == 5'd15) ? MUL_WAIT : (op == 5'd16) ? DIV_WAIT : 0);
            for (int k = 0; k < n_exec; k++) begin
                e = '0; e.busy = 1; e.alu = op;
                if (it) e.c_out = 1;
                else if (ut) begin e.grb = 1; e.r_out = 1; end
                else begin e.grc = 1; e.r_out = 1; end
                e.z_in = (k == n_exec - 1);
                exp_q.push_back(e);
            end
            e = '0; e.busy = 1; e.zlo_out = 1;
            if (md) e.lo_in = 1;
            else begin e.gra = 1; e.r_in = 1; end
            exp_q.push_back(e);
            if (md) begin
                e = '0; e.busy = 1; e.zhi_out = 1; e.hi_in = 1;
                exp_q.push_back(e);
            end
            e = '0; e.busy = 1; e.done = 1;
            exp_q.push_back(e);
        end
    endtask

    // Called at the first negedge after the accepting edge; checks every cycle up to idle.
    task automatic check_seq(input string nm, input bit noise, input bit keep,
                             output int lat, output logic err_done);
        obs_t e;
        lat = 0;
        err_done = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clock);
            cmp(nm, obs, exp_q[i]);
            if (obs.done && lat == 0) begin
                lat = i + 1;
                err_done = obs.error;
            end
            if (noise) begin
                start  = 1'($urandom_range(0, 1));
                opcode = 5'($urandom);
            end
        end
        @(negedge clock);
        if (!keep) start = 1'b0;
        e = '0; e.error = exp_err;
        cmp({nm, "_idle"}, obs, e);
    endtask

    task automatic run_op(input string nm, input logic [4:0] op, input bit noise,
                          output int lat, output logic err_done);
        @(negedge clock);
        start  = 1'b1;
        opcode = op;
        build_exp(op);
        @(negedge clock);
        start  = 1'b0;
        opcode = 5'($urandom);
        check_seq(nm, noise, 1'b0, lat, err_done);
    endtask

    initial begin
        vec_t vecs[$];
        int   lat;
        logic err_done;
        int   strobes;
        obs_t zero;
        zero = '0;

        vecs.push_back('{5'd3,  4, 1'b0});
        vecs.push_back('{5'd11, 4, 1'b0});
        vecs.push_back('{5'd12, 4, 1'b0});
        vecs.push_back('{5'd14, 4, 1'b0});
        vecs.push_back('{5'd17, 3, 1'b0});
        vecs.push_back('{5'd18, 3, 1'b0});
        vecs.push_back('{5'd15, 5 + MUL_WAIT, 1'b0});
        vecs.push_back('{5'd16, 5 + DIV_WAIT, 1'b0});
        vecs.push_back('{5'd21, 1, 1'b1});
        vecs.push_back('{5'd3,  4, 1'b0});
        vecs.push_back('{5'd2,  1, 1'b1});
        vecs.push_back('{5'd19, 1, 1'b1});
        vecs.push_back('{5'd0,  1, 1'b1});
        vecs.push_back('{5'd31, 1, 1'b1});

        #2;
        cmp("reset", obs, zero);
        @(negedge clock);
        clear = 1'b0;
        cmp("reset_release", obs, zero);

        foreach (vecs[i]) begin
            run_op("vec_seq", vecs[i].op, 1'b0, lat, err_done);
            checks++;
            if (lat != vecs[i].lat || err_done !== vecs[i].err) begin
                errors++;
                $display("FAIL vec_lat op=%0d got lat=%0d err=%0b exp lat=%0d err=%0b",
                         vecs[i].op, lat, err_done, vecs[i].lat, vecs[i].err);
            end
        end

        for (int r = 0; r < 40; r++) begin
            run_op("rand_seq", 5'($urandom_range(0, 31)), 1'b1, lat, err_done);
        end

        // start held high across two adds: second accepted only from IDLE
        @(negedge clock);
        start  = 1'b1;
        opcode = 5'd3;
        build_exp(5'd3);
        @(negedge clock);
        check_seq("hold_first", 1'b0, 1'b1, lat, err_done);
        @(negedge clock);
        check_seq("hold_second", 1'b0, 1'b0, lat, err_done);

        // clear asserted in the 2nd WAIT cycle of a div
        @(negedge clock);
        start  = 1'b1;
        opcode = 5'd16;
        @(negedge clock);
        start  = 1'b0;
        repeat (3) @(negedge clock);
        clear = 1'b1;
        #1;
        cmp("clear_same_cycle", obs, zero);
        @(negedge clock);
        cmp("clear_held", obs, zero);
        clear = 1'b0;
        strobes = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (obs !== zero) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL clear_no_writeback got %0d active cycles exp 0", strobes);
        end
        run_op("after_clear", 5'd3, 1'b0, lat, err_done);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL after_clear_lat got %0d exp 4", lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
